// File: rtl/uart_apb_regif.sv
// APB slave register interface for a UART: DATA/STATUS/CTRL registers fronting a TX and an RX FIFO.
// Every transfer walks a small FSM so FIFO stalls become APB wait states, or a timed-out error.
module uart_apb_regif #(
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 16,
  parameter int RST_CYCLES = 15
) (
  input  logic              pclk,
  input  logic              PRESETn,
  input  logic [31:0]       PADDR,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [DATA_W-1:0] rx_fifo_dataOut,
  input  logic              rx_fifo_Full,
  input  logic              rx_fifo_Empty,
  input  logic              tx_fifo_Full,
  output logic              tx_fifo_writeEn,
  output logic              rx_fifo_readEn,
  output logic [DATA_W-1:0] tx_fifo_dataIn,
  output logic              uart_reset,
  output logic              irq
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT_TX, WAIT_RX, RD_DATA, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [RST_W-1:0]  rstCnt_q, rstCnt_d;
  logic [31:0]       prdata_q, prdata_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic              pready_q, pslverr_q, irq_q;
  logic              txErr_q, txErr_d, rxErr_q, rxErr_d;
  logic              rxIe_q, rxIe_d, txIe_q, txIe_d;
  logic              rstPend_q, rstPend_d;
  logic              err, txErrSet, rxErrSet, rstLoad, txPush, rxPop;
  logic [1:0]        w1c;
  logic [31:0]       statusWord;
  logic              unusedBits;

  assign statusWord = {27'd0, rxErr_q, txErr_q, tx_fifo_Full, rx_fifo_Full, rx_fifo_Empty};
  assign unusedBits = ^{PADDR[31:4], PADDR[1:0], PWDATA};

  // Strobes are combinational so they only ever exist while the FSM sits in a wait state
  // with the slave still selected; an abort or reset drops them in the same cycle.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    prdata_d  = '0;
    txData_d  = txData_q;
    rxIe_d    = rxIe_q;
    txIe_d    = txIe_q;
    rstPend_d = rstPend_q;
    err       = 1'b0;
    txErrSet  = 1'b0;
    rxErrSet  = 1'b0;
    rstLoad   = 1'b0;
    txPush    = 1'b0;
    rxPop     = 1'b0;
    w1c       = 2'b00;
    case (state_q)
      IDLE: if (PSELx && !PENABLE) state_d = ACCESS;
      ACCESS: begin
        if (!PSELx) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          case (PADDR[3:2])
            2'd0: begin
              if (PWRITE) begin
                txData_d = PWDATA[DATA_W-1:0];
                state_d  = WAIT_TX;
              end else begin
                state_d  = WAIT_RX;
              end
            end
            2'd1: begin
              state_d = DONE;
              if (PWRITE) w1c = PWDATA[4:3];
              else        prdata_d = statusWord;
            end
            2'd2: begin
              state_d = DONE;
              if (PWRITE) begin
                rxIe_d    = PWDATA[1];
                txIe_d    = PWDATA[2];
                rstPend_d = PWDATA[0];
              end else begin
                prdata_d  = {29'd0, txIe_q, rxIe_q, 1'b0};
              end
            end
            default: begin
              state_d = DONE;
              err     = 1'b1;
            end
          endcase
        end
      end
      WAIT_TX: begin
        if (!PSELx) begin
          state_d = IDLE;
        end else if (!tx_fifo_Full) begin
          txPush  = 1'b1;
          state_d = DONE;
        end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
          err      = 1'b1;
          txErrSet = 1'b1;
          state_d  = DONE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      WAIT_RX: begin
        if (!PSELx) begin
          state_d = IDLE;
        end else if (!rx_fifo_Empty) begin
          rxPop   = 1'b1;
          state_d = RD_DATA;
        end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
          err      = 1'b1;
          rxErrSet = 1'b1;
          state_d  = DONE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      RD_DATA: begin
        if (!PSELx) begin
          state_d = IDLE;
        end else begin
          prdata_d = 32'(rx_fifo_dataOut);
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (rstPend_q) begin
          rstLoad   = 1'b1;
          rstPend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky errors: a set in the same cycle as a write-1-to-clear takes priority.
  always_comb begin
    txErr_d  = txErrSet | (txErr_q & ~w1c[0]);
    rxErr_d  = rxErrSet | (rxErr_q & ~w1c[1]);
    rstCnt_d = rstLoad ? RST_W'(RST_CYCLES) : ((rstCnt_q != '0) ? rstCnt_q - 1'b1 : '0);
  end

  always_ff @(posedge pclk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      rstCnt_q  <= '0;
      prdata_q  <= '0;
      txData_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      irq_q     <= 1'b0;
      txErr_q   <= 1'b0;
      rxErr_q   <= 1'b0;
      rxIe_q    <= 1'b0;
      txIe_q    <= 1'b0;
      rstPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      rstCnt_q  <= rstCnt_d;
      prdata_q  <= prdata_d;
      txData_q  <= txData_d;
      pready_q  <= (state_d == DONE);
      pslverr_q <= err;
      irq_q     <= (rxIe_q & ~rx_fifo_Empty) | (txIe_q & ~tx_fifo_Full) | txErr_q | rxErr_q;
      txErr_q   <= txErr_d;
      rxErr_q   <= rxErr_d;
      rxIe_q    <= rxIe_d;
      txIe_q    <= txIe_d;
      rstPend_q <= rstPend_d;
    end
  end

  assign PRDATA          = prdata_q;
  assign PREADY          = pready_q;
  assign PSLVERR         = pslverr_q;
  assign tx_fifo_writeEn = txPush;
  assign rx_fifo_readEn  = rxPop;
  assign tx_fifo_dataIn  = txData_q;
  assign uart_reset      = (rstCnt_q != '0);
  assign irq             = irq_q;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Self-checking bench for uart_apb_regif: APB transfers against a scoreboard of expected
// completions, plus sticky-error, soft-reset, abort and async-reset scenarios.
module tb_uart_apb_regif;
  localparam int TIMEOUT    = 16;
  localparam int RST_CYCLES = 15;

  logic        pclk = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0]  rx_fifo_dataOut = 8'hEE;
  logic        rx_fifo_Full, rx_fifo_Empty, tx_fifo_Full;
  logic        tx_fifo_writeEn, rx_fifo_readEn, uart_reset, irq;
  logic [7:0]  tx_fifo_dataIn;

  typedef struct {
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    int          txS;
    int          rxS;
    logic [7:0]  txData;
  } exp_t;

  exp_t       expQ[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  logic [7:0] rxHead = 8'h00;
  logic       rxPopSeen;
  logic       mTxErr, mRxErr, mRxIe, mTxIe;

  uart_apb_regif #(.DATA_W(8), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)) dut (
    .pclk(pclk), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .rx_fifo_dataOut(rx_fifo_dataOut), .rx_fifo_Full(rx_fifo_Full), .rx_fifo_Empty(rx_fifo_Empty),
    .tx_fifo_Full(tx_fifo_Full), .tx_fifo_writeEn(tx_fifo_writeEn), .rx_fifo_readEn(rx_fifo_readEn),
    .tx_fifo_dataIn(tx_fifo_dataIn), .uart_reset(uart_reset), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // RX FIFO model: head word appears only in the cycle after a pop, garbage otherwise.
  always @(posedge pclk) begin
    rxPopSeen = rx_fifo_readEn;
    #1;
    rx_fifo_dataOut = rxPopSeen ? rxHead : 8'hEE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input logic [31:0] prdata, input logic slverr, input int waits,
                            input int txS, input int rxS, input logic [7:0] txData);
    exp_t e;
    e.prdata = prdata; e.slverr = slverr; e.waits = waits;
    e.txS = txS; e.rxS = rxS; e.txData = txData;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] statusExp();
    return {27'd0, mRxErr, mTxErr, tx_fifo_Full, rx_fifo_Full, rx_fifo_Empty};
  endfunction

  function automatic logic expIrq();
    return (mRxIe & ~rx_fifo_Empty) | (mTxIe & ~tx_fifo_Full) | mTxErr | mRxErr;
  endfunction

  // One full APB transfer; wait states are the enable-phase samples with PREADY low.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input string tag);
    int waits = 0;
    int txS = 0;
    int rxS = 0;
    logic [7:0] pushData = 8'h00;
    exp_t e;
    @(negedge pclk);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    @(negedge pclk);
    PENABLE = 1'b1;
    while (PREADY !== 1'b1 && waits < 64) begin
      if (tx_fifo_writeEn === 1'b1) begin txS++; pushData = tx_fifo_dataIn; end
      if (rx_fifo_readEn === 1'b1) rxS++;
      waits++;
      @(negedge pclk);
    end
    if (PREADY !== 1'b1) checkOutput({tag, " pready"}, {31'd0, PREADY}, 32'd1);
    if (tx_fifo_writeEn === 1'b1) txS++;
    if (rx_fifo_readEn === 1'b1) rxS++;
    if (expQ.size() == 0) begin
      checkOutput({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, " waits"}, waits, e.waits);
      checkOutput({tag, " pslverr"}, {31'd0, PSLVERR}, {31'd0, e.slverr});
      checkOutput({tag, " prdata"}, PRDATA, e.prdata);
      checkOutput({tag, " tx strobes"}, txS, e.txS);
      checkOutput({tag, " rx strobes"}, rxS, e.rxS);
      if (e.txS == 1) checkOutput({tag, " tx data"}, {24'd0, pushData}, {24'd0, e.txData});
    end
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hi, firstHi, cnt, rdy;
    PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    rx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1; tx_fifo_Full = 1'b0;
    mTxErr = 0; mRxErr = 0; mRxIe = 0; mTxIe = 0;
    repeat (3) @(negedge pclk);
    checkOutput("rst pready", {31'd0, PREADY}, 32'd0);
    checkOutput("rst pslverr", {31'd0, PSLVERR}, 32'd0);
    checkOutput("rst prdata", PRDATA, 32'd0);
    checkOutput("rst strobes", {30'd0, tx_fifo_writeEn, rx_fifo_readEn}, 32'd0);
    checkOutput("rst txdata", {24'd0, tx_fifo_dataIn}, 32'd0);
    checkOutput("rst uart_reset", {31'd0, uart_reset}, 32'd0);
    checkOutput("rst irq", {31'd0, irq}, 32'd0);
    PRESETn = 1'b1;

    pushExpect(32'd0, 1'b0, 2, 1, 0, 8'h5A);
    applyStimulus(32'h0, 1'b1, 32'h0000_005A, "tx push");

    rxHead = 8'hC3; rx_fifo_Empty = 1'b0;
    pushExpect(32'h0000_00C3, 1'b0, 3, 0, 1, 8'h00);
    applyStimulus(32'h0, 1'b0, 32'h0, "rx pop");

    rx_fifo_Empty = 1'b1;
    pushExpect(statusExp(), 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b0, 32'h0, "status idle");

    tx_fifo_Full = 1'b1;
    pushExpect(32'd0, 1'b1, 1 + TIMEOUT, 0, 0, 8'h00);
    applyStimulus(32'h0, 1'b1, 32'h0000_0077, "tx timeout");
    mTxErr = 1;
    tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b0;
    pushExpect(32'h0000_0008, 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b0, 32'h0, "status txerr");
    checkOutput("irq txerr", {31'd0, irq}, {31'd0, expIrq()});
    pushExpect(32'd0, 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b1, 32'h0000_0008, "w1c txerr");
    mTxErr = 0;
    pushExpect(statusExp(), 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b0, 32'h0, "status cleared");
    checkOutput("irq cleared", {31'd0, irq}, {31'd0, expIrq()});

    rx_fifo_Empty = 1'b1;
    pushExpect(32'd0, 1'b1, 1 + TIMEOUT, 0, 0, 8'h00);
    applyStimulus(32'h0, 1'b0, 32'h0, "rx timeout");
    mRxErr = 1;
    pushExpect(statusExp(), 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b0, 32'h0, "status rxerr");
    pushExpect(32'd0, 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b1, 32'h0000_0010, "w1c rxerr");
    mRxErr = 0;
    rx_fifo_Empty = 1'b0; rx_fifo_Full = 1'b1; tx_fifo_Full = 1'b1;
    pushExpect(statusExp(), 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b0, 32'h0, "status flags");
    rx_fifo_Full = 1'b0;

    pushExpect(32'd0, 1'b1, 1, 0, 0, 8'h00);
    applyStimulus(32'hC, 1'b1, 32'hFFFF_FFFF, "unmapped wr");
    pushExpect(32'd0, 1'b1, 1, 0, 0, 8'h00);
    applyStimulus(32'h1000_000C, 1'b0, 32'h0, "unmapped rd");

    pushExpect(32'd0, 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h8, 1'b1, 32'h0000_0007, "ctrl wr");
    mRxIe = 1; mTxIe = 1;
    hi = 0; firstHi = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (uart_reset === 1'b1) begin
        if (firstHi < 0) firstHi = i;
        hi++;
      end
    end
    checkOutput("softrst start", firstHi, 32'd0);
    checkOutput("softrst len", hi, RST_CYCLES);
    pushExpect(32'h0000_0006, 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h8, 1'b0, 32'h0, "ctrl rd");
    checkOutput("irq rx term", {31'd0, irq}, {31'd0, expIrq()});
    rx_fifo_Empty = 1'b1;
    repeat (2) @(negedge pclk);
    checkOutput("irq none", {31'd0, irq}, {31'd0, expIrq()});
    tx_fifo_Full = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("irq tx term", {31'd0, irq}, {31'd0, expIrq()});

    // Abort: deselect while stalled in WAIT_TX, then unblock the FIFO.
    tx_fifo_Full = 1'b1;
    @(negedge pclk);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b1; PWDATA = 32'h11;
    @(negedge pclk);
    PENABLE = 1'b1;
    repeat (4) @(negedge pclk);
    PSELx = 1'b0; PENABLE = 1'b0; tx_fifo_Full = 1'b0;
    cnt = 0; rdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_fifo_writeEn === 1'b1) cnt++;
      if (PREADY === 1'b1) rdy++;
      @(negedge pclk);
    end
    checkOutput("abort strobes", cnt, 32'd0);
    checkOutput("abort pready", rdy, 32'd0);
    pushExpect(statusExp(), 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h4, 1'b0, 32'h0, "status after abort");

    // Reset asserted while stalled in WAIT_RX.
    rx_fifo_Empty = 1'b1;
    @(negedge pclk);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 32'h0; PWRITE = 1'b0;
    @(negedge pclk);
    PENABLE = 1'b1;
    repeat (3) @(negedge pclk);
    checkOutput("pre-reset irq", {31'd0, irq}, {31'd0, expIrq()});
    PRESETn = 1'b0;
    #1;
    mTxErr = 0; mRxErr = 0; mRxIe = 0; mTxIe = 0;
    checkOutput("midrst pready", {31'd0, PREADY}, 32'd0);
    checkOutput("midrst strobes", {30'd0, tx_fifo_writeEn, rx_fifo_readEn}, 32'd0);
    checkOutput("midrst txdata", {24'd0, tx_fifo_dataIn}, 32'd0);
    checkOutput("midrst irq", {31'd0, irq}, 32'd0);
    checkOutput("midrst prdata", PRDATA, 32'd0);
    rx_fifo_Empty = 1'b0;
    @(negedge pclk);
    PRESETn = 1'b1;
    @(posedge pclk);
    #1;
    checkOutput("post-release strobe", {31'd0, rx_fifo_readEn}, 32'd0);
    @(negedge pclk);
    PSELx = 1'b0; PENABLE = 1'b0;

    pushExpect(32'd0, 1'b0, 1, 0, 0, 8'h00);
    applyStimulus(32'h8, 1'b0, 32'h0, "ctrl after reset");
    pushExpect(32'd0, 1'b0, 2, 1, 0, 8'hA5);
    applyStimulus(32'h0, 1'b1, 32'hDEAD_BEA5, "tx push 2");

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/uart_apb_regif.md
UART_APB_REGIF -- requirements
Module: uart_apb_regif

Interface
REQ-001 SHALL have parameter DATA_W, default 8, UART FIFO data width (1..32).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum wait cycles on a blocked FIFO before an error completion.
REQ-003 SHALL have parameter RST_CYCLES, default 15, soft-reset pulse length in pclk cycles.
REQ-004 pclk  in  1  single clock; all logic on rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 PADDR  in  32  byte address; bits [3:2] decoded, others ignored.
REQ-007 PSELx, PENABLE, PWRITE  in  1 each  APB select, enable, direction.
REQ-008 PWDATA  in  32  write data.  PRDATA  out  32  read data, registered.
REQ-009 PREADY, PSLVERR  out  1 each  transfer complete / error, registered.
REQ-010 rx_fifo_dataOut  in  DATA_W  RX FIFO head; valid the cycle after rx_fifo_readEn.
REQ-011 rx_fifo_Full, rx_fifo_Empty, tx_fifo_Full  in  1 each  FIFO flags.
REQ-012 tx_fifo_writeEn, rx_fifo_readEn  out  1 each  single-cycle FIFO strobes.
REQ-013 tx_fifo_dataIn  out  DATA_W  PWDATA[DATA_W-1:0], registered at push.
REQ-014 uart_reset  out  1  UART soft reset, active-high.  irq  out  1  level interrupt.

Function
REQ-015 Register map (offset): 0x0 DATA (W pushes TX, R pops RX); 0x4 STATUS (R); 0x8 CTRL (R/W); 0xC unmapped.
REQ-016 STATUS: bit0 rx_empty, bit1 rx_full, bit2 tx_full (live); bit3 tx_err, bit4 rx_err (sticky); write-1-to-clear bits 3/4, other written bits ignored.
REQ-017 CTRL: bit0 soft_rst (self-clearing, reads 0), bit1 rx_ie, bit2 tx_ie; bits [31:3] read 0.
REQ-018 FSM states IDLE, ACCESS, WAIT_TX, WAIT_RX, RD_DATA, DONE.
REQ-019 IDLE -> ACCESS when PSELx=1 and PENABLE=0; PREADY low in every state except DONE.
REQ-020 ACCESS (PENABLE=1): DATA write -> WAIT_TX; DATA read -> WAIT_RX; STATUS/CTRL -> DONE with data/side effect applied; 0xC -> DONE with PSLVERR=1, no side effect.
REQ-021 WAIT_TX: if tx_fifo_Full=0, pulse tx_fifo_writeEn one cycle, go DONE (PREADY rises next cycle); else increment wait counter.
REQ-022 WAIT_RX: if rx_fifo_Empty=0, pulse rx_fifo_readEn one cycle, go RD_DATA; else increment wait counter.
REQ-023 RD_DATA: capture zero-extended rx_fifo_dataOut into PRDATA, go DONE.
REQ-024 Wait counter reaching TIMEOUT in WAIT_TX/WAIT_RX: go DONE with PSLVERR=1, no strobe, set tx_err/rx_err respectively, PRDATA=0.
REQ-025 DONE: PREADY=1 for exactly one cycle, PSLVERR valid only then; return to IDLE; counter cleared.
REQ-026 Minimum latency: register access 1 wait state; DATA write 2; DATA read 3 (PREADY in 4th cycle after setup).
REQ-027 At most one FIFO strobe per transfer; strobes never asserted outside WAIT_TX/WAIT_RX.
REQ-028 PSELx deasserted mid-transfer: abort to IDLE, no strobe afterwards, no PREADY.
REQ-029 Write 1 to CTRL.soft_rst: uart_reset high for RST_CYCLES cycles starting the cycle after DONE; a re-write while active restarts the count.
REQ-030 irq = (rx_ie & ~rx_empty) | (tx_ie & ~tx_full) | tx_err | rx_err, registered.
REQ-031 Simultaneous sticky set and W1C clear in the same cycle: set wins.

Reset
REQ-032 PRESETn low: FSM IDLE, PREADY=0, PSLVERR=0, PRDATA=0, strobes 0, tx_fifo_dataIn=0, uart_reset=0, irq=0, CTRL=0, sticky bits 0, counters 0.
REQ-033 Reset asserted mid-transfer aborts immediately; no strobe on the first edge after release.

Verification
REQ-034 Write 0x5A to 0x0, tx_fifo_Full=0 -> one tx_fifo_writeEn pulse, tx_fifo_dataIn=0x5A, PREADY after 2 wait states, PSLVERR=0.
REQ-035 Read 0x0, rx_fifo_Empty=0, dataOut=0xC3 -> one rx_fifo_readEn pulse, PRDATA=0x000000C3, 3 wait states.
REQ-036 Write 0x0 with tx_fifo_Full held 1 -> no strobe, PREADY+PSLVERR after TIMEOUT=16 waits, STATUS reads 0x08 bit3 set, irq=1; write 0x08 to 0x4 clears it.
REQ-037 Write 0x1 to 0x8 -> uart_reset high exactly 15 cycles, CTRL reads 0.
REQ-038 Access 0xC -> PSLVERR=1, no strobes; PRESETn low during WAIT_RX -> all outputs to reset values within the same cycle.
